// File: rtl/sodor_request_router_n.sv
// Request router: steers one core memory port to NUM_TARGETS address regions and
// returns responses in order via an ID FIFO; unmapped addresses get a local error reply.
module sodor_request_router_n #(
  parameter int unsigned                 NUM_TARGETS     = 2,
  parameter int unsigned                 XLEN            = 32,
  parameter int unsigned                 MAX_OUTSTANDING = 4,
  parameter logic [NUM_TARGETS*XLEN-1:0] REGION_BASE     = {32'h00000000, 32'h80000000},
  parameter logic [NUM_TARGETS*XLEN-1:0] REGION_MASK     = {32'h00000000, 32'hFFFC0000}
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               core_req_valid,
  output logic                               core_req_ready,
  input  logic [XLEN-1:0]                    core_req_addr,
  input  logic [XLEN-1:0]                    core_req_data,
  input  logic                               core_req_fcn,
  input  logic [2:0]                         core_req_typ,
  output logic                               core_resp_valid,
  output logic [XLEN-1:0]                    core_resp_data,
  output logic                               core_resp_err,
  output logic [NUM_TARGETS-1:0]             tgt_req_valid,
  input  logic [NUM_TARGETS-1:0]             tgt_req_ready,
  output logic [NUM_TARGETS*XLEN-1:0]        tgt_req_addr,
  output logic [NUM_TARGETS*XLEN-1:0]        tgt_req_data,
  output logic [NUM_TARGETS-1:0]             tgt_req_fcn,
  output logic [NUM_TARGETS*3-1:0]           tgt_req_typ,
  input  logic [NUM_TARGETS-1:0]             tgt_resp_valid,
  input  logic [NUM_TARGETS*XLEN-1:0]        tgt_resp_data,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               protocol_err
);

  localparam int unsigned IDW  = $clog2(NUM_TARGETS + 1);
  localparam int unsigned PTRW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNTW = PTRW + 1;
  localparam logic [IDW-1:0] ERR_ID = IDW'(NUM_TARGETS);

  logic [IDW-1:0]  sel;
  logic            found;
  logic            selReady;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            unexpected;
  logic [IDW-1:0]  headId;
  logic [IDW-1:0]  idFifo [MAX_OUTSTANDING];
  logic [PTRW-1:0] headPtr;
  logic [PTRW-1:0] tailPtr;
  logic [CNTW-1:0] count;
  logic            protocolErr;

  // Lowest-indexed matching region wins; no match selects the local error path.
  always_comb begin
    sel      = ERR_ID;
    found    = 1'b0;
    selReady = 1'b0;
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (!found && ((core_req_addr & REGION_MASK[i*XLEN +: XLEN]) == REGION_BASE[i*XLEN +: XLEN])) begin
        sel   = IDW'(i);
        found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (sel == IDW'(i)) selReady = tgt_req_ready[i];
    end
  end

  assign full           = (count == CNTW'(MAX_OUTSTANDING));
  assign empty          = (count == '0);
  assign core_req_ready = !full && ((sel == ERR_ID) || selReady);
  assign push           = core_req_valid && core_req_ready;

  always_comb begin
    tgt_req_valid = '0;
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      tgt_req_valid[i] = reset && core_req_valid && (sel == IDW'(i)) && !full;
    end
  end

  assign tgt_req_addr = {NUM_TARGETS{core_req_addr}};
  assign tgt_req_data = {NUM_TARGETS{core_req_data}};
  assign tgt_req_fcn  = {NUM_TARGETS{core_req_fcn}};
  assign tgt_req_typ  = {NUM_TARGETS{core_req_typ}};

  assign headId = idFifo[headPtr];

  // Only the head target may respond; anything else is dropped and flagged.
  always_comb begin
    core_resp_valid = 1'b0;
    core_resp_data  = '0;
    core_resp_err   = 1'b0;
    pop             = 1'b0;
    unexpected      = 1'b0;
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (!empty && (headId == IDW'(i))) begin
        core_resp_valid = tgt_resp_valid[i];
        core_resp_data  = tgt_resp_data[i*XLEN +: XLEN];
        pop             = tgt_resp_valid[i];
      end else if (tgt_resp_valid[i]) begin
        unexpected = 1'b1;
      end
    end
    if (!empty && (headId == ERR_ID)) begin
      core_resp_valid = 1'b1;
      core_resp_err   = 1'b1;
      pop             = 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone defines which entries are live.
  always_ff @(posedge clock) begin
    if (push) idFifo[tailPtr] <= sel;
  end

  // Reset release is expected to be synchronous to clock at the system level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      headPtr     <= '0;
      tailPtr     <= '0;
      count       <= '0;
      protocolErr <= 1'b0;
    end else begin
      if (push) tailPtr <= tailPtr + PTRW'(1);
      if (pop)  headPtr <= headPtr + PTRW'(1);
      if (push && !pop)      count <= count + CNTW'(1);
      else if (!push && pop) count <= count - CNTW'(1);
      if (unexpected) protocolErr <= 1'b1;
    end
  end

  assign outstanding  = count;
  assign protocol_err = protocolErr;

endmodule

// File: tb/tb_sodor_request_router_n.sv
// Directed bench for sodor_request_router_n: default-map instance plus an instance
// with a sparse map that leaves holes for the error-response path.
module tb_sodor_request_router_n;

  logic        clock;
  logic        reset;
  int unsigned checks;
  int unsigned failures;

  logic        aReqValid, aReqReady, aReqFcn, aRespValid, aRespErr, aProtoErr;
  logic [31:0] aReqAddr, aReqData, aRespData;
  logic [2:0]  aReqTyp, aOutstanding;
  logic [1:0]  aTgtReqValid, aTgtReqReady, aTgtReqFcn, aTgtRespValid;
  logic [63:0] aTgtReqAddr, aTgtReqData, aTgtRespData;
  logic [5:0]  aTgtReqTyp;

  logic        bReqValid, bReqReady, bReqFcn, bRespValid, bRespErr, bProtoErr;
  logic [31:0] bReqAddr, bReqData, bRespData;
  logic [2:0]  bReqTyp, bOutstanding;
  logic [1:0]  bTgtReqValid, bTgtReqReady, bTgtReqFcn, bTgtRespValid;
  logic [63:0] bTgtReqAddr, bTgtReqData, bTgtRespData;
  logic [5:0]  bTgtReqTyp;

  sodor_request_router_n dutA (
    .clock(clock), .reset(reset),
    .core_req_valid(aReqValid), .core_req_ready(aReqReady), .core_req_addr(aReqAddr),
    .core_req_data(aReqData), .core_req_fcn(aReqFcn), .core_req_typ(aReqTyp),
    .core_resp_valid(aRespValid), .core_resp_data(aRespData), .core_resp_err(aRespErr),
    .tgt_req_valid(aTgtReqValid), .tgt_req_ready(aTgtReqReady), .tgt_req_addr(aTgtReqAddr),
    .tgt_req_data(aTgtReqData), .tgt_req_fcn(aTgtReqFcn), .tgt_req_typ(aTgtReqTyp),
    .tgt_resp_valid(aTgtRespValid), .tgt_resp_data(aTgtRespData),
    .outstanding(aOutstanding), .protocol_err(aProtoErr)
  );

  sodor_request_router_n #(
    .NUM_TARGETS(2),
    .XLEN(32),
    .MAX_OUTSTANDING(4),
    .REGION_BASE({32'h10000000, 32'h80000000}),
    .REGION_MASK({32'hF0000000, 32'hFFFC0000})
  ) dutB (
    .clock(clock), .reset(reset),
    .core_req_valid(bReqValid), .core_req_ready(bReqReady), .core_req_addr(bReqAddr),
    .core_req_data(bReqData), .core_req_fcn(bReqFcn), .core_req_typ(bReqTyp),
    .core_resp_valid(bRespValid), .core_resp_data(bRespData), .core_resp_err(bRespErr),
    .tgt_req_valid(bTgtReqValid), .tgt_req_ready(bTgtReqReady), .tgt_req_addr(bTgtReqAddr),
    .tgt_req_data(bTgtReqData), .tgt_req_fcn(bTgtReqFcn), .tgt_req_typ(bTgtReqTyp),
    .tgt_resp_valid(bTgtRespValid), .tgt_resp_data(bTgtRespData),
    .outstanding(bOutstanding), .protocol_err(bProtoErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0;
    aReqValid = 1'b0; aReqAddr = '0; aReqData = '0; aReqFcn = 1'b0; aReqTyp = 3'd2;
    aTgtReqReady = 2'b11; aTgtRespValid = 2'b00; aTgtRespData = '0;
    bReqValid = 1'b0; bReqAddr = '0; bReqData = '0; bReqFcn = 1'b0; bReqTyp = 3'd2;
    bTgtReqReady = 2'b11; bTgtRespValid = 2'b00; bTgtRespData = '0;

    // During reset: forwarding suppressed, ready still follows decode
    @(negedge clock);
    aReqValid = 1'b1; aReqAddr = 32'h80000010; #1;
    check("rst_tgt_req_valid", 64'(aTgtReqValid), 64'd0);
    check("rst_req_ready",     64'(aReqReady),    64'd1);
    check("rst_outstanding",   64'(aOutstanding), 64'd0);
    check("rst_resp_valid",    64'(aRespValid),   64'd0);
    check("rst_protocol_err",  64'(aProtoErr),    64'd0);
    @(negedge clock);
    aReqValid = 1'b0; reset = 1'b1;

    // Unmapped address on the sparse-map instance
    @(negedge clock);
    bReqValid = 1'b1; bReqAddr = 32'h40000000; bTgtReqReady = 2'b00;
    bTgtRespData = 64'hFFFFFFFF_FFFFFFFF; #1;
    check("err_tgt_req_valid",  64'(bTgtReqValid), 64'd0);
    check("err_req_ready",      64'(bReqReady),    64'd1);
    check("err_resp_same_cyc",  64'(bRespValid),   64'd0);
    @(negedge clock);
    bReqValid = 1'b0; #1;
    check("err_resp_valid",     64'(bRespValid),   64'd1);
    check("err_resp_err",       64'(bRespErr),     64'd1);
    check("err_resp_data",      64'(bRespData),    64'd0);
    check("err_outstanding",    64'(bOutstanding), 64'd1);
    @(negedge clock); #1;
    check("err_drained",        64'(bOutstanding), 64'd0);
    check("err_resp_gone",      64'(bRespValid),   64'd0);
    bReqValid = 1'b1; bReqAddr = 32'h10000004; bTgtReqReady = 2'b11; #1;
    check("b_t1_tgt_req_valid", 64'(bTgtReqValid), 64'd2);
    @(negedge clock);
    bReqValid = 1'b0; bTgtRespValid = 2'b10; bTgtRespData = {32'h0000BEEF, 32'h0}; #1;
    check("b_t1_resp_data",     64'(bRespData),    64'h0000BEEF);
    @(negedge clock);
    bTgtRespValid = 2'b01; #1;
    check("b_empty_resp_valid", 64'(bRespValid),   64'd0);
    @(negedge clock);
    bTgtRespValid = 2'b00; #1;
    check("b_empty_proto_err",  64'(bProtoErr),    64'd1);

    // Single load to target 0
    @(negedge clock);
    aReqValid = 1'b1; aReqAddr = 32'h80000010; aReqFcn = 1'b0; #1;
    check("t1_tgt_req_valid",   64'(aTgtReqValid), 64'd1);
    check("t1_req_ready",       64'(aReqReady),    64'd1);
    check("t1_tgt_req_addr",    aTgtReqAddr,       {32'h80000010, 32'h80000010});
    @(negedge clock);
    aReqValid = 1'b0; #1;
    check("t1_outstanding_1",   64'(aOutstanding), 64'd1);
    check("t1_no_resp_yet",     64'(aRespValid),   64'd0);
    @(negedge clock);
    aTgtRespValid = 2'b01; aTgtRespData = {32'h0, 32'h00001234}; #1;
    check("t1_resp_valid",      64'(aRespValid),   64'd1);
    check("t1_resp_data",       64'(aRespData),    64'h1234);
    check("t1_resp_err",        64'(aRespErr),     64'd0);
    @(negedge clock);
    aTgtRespValid = 2'b00; #1;
    check("t1_outstanding_0",   64'(aOutstanding), 64'd0);
    check("t1_proto_clean",     64'(aProtoErr),    64'd0);

    // Out-of-order response from target 1 is dropped
    @(negedge clock);
    aReqValid = 1'b1; aReqAddr = 32'h80000000; #1;
    check("t2_first_t0",        64'(aTgtReqValid), 64'd1);
    @(negedge clock);
    aReqAddr = 32'h00001000; #1;
    check("t2_second_t1",       64'(aTgtReqValid), 64'd2);
    @(negedge clock);
    aReqValid = 1'b0; aTgtRespValid = 2'b10; aTgtRespData = {32'h0000BBBB, 32'h0}; #1;
    check("t2_outstanding_2",   64'(aOutstanding), 64'd2);
    check("t2_wrong_resp_blk",  64'(aRespValid),   64'd0);
    @(negedge clock);
    aTgtRespValid = 2'b01; aTgtRespData = {32'h0, 32'h0000AAAA}; #1;
    check("t2_proto_err",       64'(aProtoErr),    64'd1);
    check("t2_still_2",         64'(aOutstanding), 64'd2);
    check("t2_t0_resp_data",    64'(aRespData),    64'hAAAA);
    @(negedge clock);
    aTgtRespValid = 2'b00; #1;
    check("t2_t1_at_head",      64'(aOutstanding), 64'd1);
    aTgtRespValid = 2'b10; aTgtRespData = {32'h0000BBBB, 32'h0}; #1;
    check("t2_t1_resp_data",    64'(aRespData),    64'hBBBB);
    @(negedge clock);
    aTgtRespValid = 2'b00; #1;
    check("t2_drained",         64'(aOutstanding), 64'd0);

    // Fill to MAX_OUTSTANDING, full blocks even with a same-cycle pop
    aReqValid = 1'b1; aReqAddr = 32'h80000020;
    repeat (4) begin
      #1 check("t4_fill_ready", 64'(aReqReady), 64'd1);
      @(negedge clock);
    end
    #1;
    check("t4_outstanding_4",   64'(aOutstanding), 64'd4);
    check("t4_full_ready",      64'(aReqReady),    64'd0);
    check("t4_full_tgt_valid",  64'(aTgtReqValid), 64'd0);
    aTgtRespValid = 2'b01; aTgtRespData = {32'h0, 32'h00005555}; #1;
    check("t4_pop_resp_valid",  64'(aRespValid),   64'd1);
    check("t4_no_bypass",       64'(aReqReady),    64'd0);
    @(negedge clock);
    aTgtRespValid = 2'b00; #1;
    check("t4_outstanding_3",   64'(aOutstanding), 64'd3);
    check("t4_fifth_ready",     64'(aReqReady),    64'd1);
    @(negedge clock);
    aReqValid = 1'b0; #1;
    check("t4_refilled",        64'(aOutstanding), 64'd4);
    aTgtRespValid = 2'b01;
    repeat (4) @(negedge clock);
    aTgtRespValid = 2'b00; #1;
    check("t4_drained",         64'(aOutstanding), 64'd0);

    // Target backpressure on a store
    aTgtReqReady = 2'b10; aReqValid = 1'b1; aReqAddr = 32'h80000000;
    aReqFcn = 1'b1; aReqData = 32'hDEADBEEF; aReqTyp = 3'd2;
    repeat (3) begin
      #1;
      check("t5_stall_ready",   64'(aReqReady),    64'd0);
      check("t5_stall_valid",   64'(aTgtReqValid), 64'd1);
      @(negedge clock);
    end
    #1;
    check("t5_no_push",         64'(aOutstanding), 64'd0);
    aTgtReqReady = 2'b11; #1;
    check("t5_ready_rise",      64'(aReqReady),    64'd1);
    check("t5_tgt_req_data",    aTgtReqData,       {32'hDEADBEEF, 32'hDEADBEEF});
    check("t5_tgt_req_fcn",     64'(aTgtReqFcn),   64'd3);
    check("t5_tgt_req_typ",     64'(aTgtReqTyp),   64'h12);
    @(negedge clock);
    aReqValid = 1'b0; aReqFcn = 1'b0; #1;
    check("t5_pushed",          64'(aOutstanding), 64'd1);
    aTgtRespValid = 2'b01; aTgtRespData = '0; #1;
    check("t5_store_resp",      64'(aRespValid),   64'd1);
    @(negedge clock);
    aTgtRespValid = 2'b00; #1;
    check("t5_drained",         64'(aOutstanding), 64'd0);

    // Asynchronous reset with requests in flight
    aReqValid = 1'b1; aReqAddr = 32'h80000040;
    repeat (3) @(negedge clock);
    aReqValid = 1'b0; #1;
    check("t6_outstanding_3",   64'(aOutstanding), 64'd3);
    aTgtRespValid = 2'b01; aReqValid = 1'b1; reset = 1'b0; #1;
    check("t6_rst_outstanding", 64'(aOutstanding), 64'd0);
    check("t6_rst_resp_valid",  64'(aRespValid),   64'd0);
    check("t6_rst_tgt_valid",   64'(aTgtReqValid), 64'd0);
    check("t6_rst_proto_err",   64'(aProtoErr),    64'd0);
    aTgtRespValid = 2'b00; aReqValid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    aReqValid = 1'b1; aReqAddr = 32'h80000010; #1;
    check("t6_fresh_tgt_valid", 64'(aTgtReqValid), 64'd1);
    @(negedge clock);
    aReqValid = 1'b0; aTgtRespValid = 2'b01; aTgtRespData = {32'h0, 32'h00004321}; #1;
    check("t6_fresh_data",      64'(aRespData),    64'h4321);
    check("t6_fresh_out_1",     64'(aOutstanding), 64'd1);
    @(negedge clock);
    aTgtRespValid = 2'b00; #1;
    check("t6_fresh_out_0",     64'(aOutstanding), 64'd0);
    check("t6_fresh_proto",     64'(aProtoErr),    64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
